reg_decr_skid: RTL and testbench
================================

REG_DECR_SKID -- requirements
Module: reg_decr_skid

Interface
REQ-001 SHALL have parameter nbits, default 8, giving the message width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-004 SHALL have port in_val  input  1  upstream message valid.
REQ-005 SHALL have port in_rdy  output  1  block can accept a message this cycle.
REQ-006 SHALL have port in_msg  input  nbits  incremented value from the upstream register-increment stage.
REQ-007 SHALL have port out_val  output  1  decoded message valid.
REQ-008 SHALL have port out_rdy  input  1  downstream can accept a message this cycle.
REQ-009 SHALL have port out_msg  output  nbits  decoded value, equal to the accepted in_msg minus 1.
REQ-010 SHALL have port underflow  output  1  sticky flag set on a wrapping decode (see Configuration).

Function
REQ-011 SHALL treat a transfer as occurring on a rising edge when val and rdy of that side are both 1.
REQ-012 SHALL store each accepted in_msg minus 1, modulo 2^nbits, in a 2-entry FIFO; in_msg = 0 decodes to all-ones.
REQ-013 SHALL present the oldest stored entry on out_msg, with out_val = 1 whenever occupancy > 0.
REQ-014 SHALL have a latency of one cycle: a message accepted at edge N is visible on out_val/out_msg after edge N.
REQ-015 SHALL drive in_rdy = 1 exactly when occupancy < 2; in_rdy SHALL NOT combinationally depend on out_rdy or in_val.
REQ-016 SHALL keep out_val and out_msg combinationally independent of in_val and in_msg (no bypass path).
REQ-017 SHALL track occupancy in {0,1,2}: enqueue only: +1; dequeue only: -1; both in the same cycle: unchanged.
REQ-018 SHALL, at occupancy 1 with simultaneous enqueue and dequeue, output the new entry on the following cycle.
REQ-019 SHALL, at occupancy 2, accept no input; a dequeue that cycle lowers occupancy to 1 and raises in_rdy on the next cycle.
REQ-020 SHALL, at occupancy 0, ignore out_rdy and produce no dequeue.
REQ-021 SHALL sustain one message per cycle in steady state while out_rdy is held at 1.
REQ-022 SHALL keep out_msg stable while out_val = 1 and out_rdy = 0.
REQ-023 SHALL preserve FIFO order with no loss or duplication.
REQ-024 SHALL leave message storage unreset; out_msg is don't-care while out_val = 0.

Reset
REQ-025 SHALL, on any edge with reset = 0, set occupancy to 0, out_val to 0, in_rdy to 0, and underflow to 0.
REQ-026 SHALL drive in_rdy = 1 on the first cycle after reset returns to 1.
REQ-027 SHALL, on reset mid-operation, discard all stored entries and ignore any handshake occurring in that cycle.

Configuration
REQ-028 SHALL use the macro REG_DECR_SKID_UNDERFLOW_EN to control the underflow flag.
REQ-029 SHALL, with the macro defined, set underflow to 1 on the edge after any accepted in_msg = 0, and hold it at 1 until reset.
REQ-030 SHALL, with the macro undefined, tie underflow to 0; the port remains present and data behaviour is identical.

Verification
REQ-031 SHALL check reset behaviour: hold reset = 0 for 3 cycles with in_val = 1 -> out_val = 0, in_rdy = 0; after release, in_rdy = 1 and out_val stays 0.
REQ-032 SHALL check streaming: nbits = 8, out_rdy = 1, send 0x01, 0x05, 0xFF on consecutive cycles -> out_msg = 0x00, 0x04, 0xFE on the next three cycles, no bubbles.
REQ-033 SHALL check backpressure: out_rdy = 0, send 0x10 and 0x20 -> in_rdy = 0 after the second; out_msg holds 0x0F; then out_rdy = 1 -> 0x0F, then 0x1F.
REQ-034 SHALL check simultaneous transfer at full: occupancy 2, out_rdy = 1, in_val = 1 -> no enqueue that cycle; occupancy becomes 1; in_rdy = 1 next cycle.
REQ-035 SHALL check wrap: send 0x00 -> out_msg = 0xFF; underflow = 1 if the macro is defined and stays 1 until reset, else underflow = 0.
REQ-036 SHALL check reset mid-operation: occupancy 2, pulse reset = 0 for one cycle -> out_val = 0; the next value sent, 0x03, emerges as 0x02.

Source files
------------

// File: rtl/reg_decr_skid.sv
// reg_decr_skid: 2-entry skid FIFO that stores each accepted message minus one (mod 2^nbits).
// Latency: one cycle from input handshake to out_val/out_msg; no combinational bypass.
// Backpressure: registered in_rdy, low only while both entries are held; independent of out_rdy.
// Optional feature: define REG_DECR_SKID_UNDERFLOW_EN to enable the sticky underflow flag.
module reg_decr_skid #(
   parameter int nbits = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [nbits-1:0] in_msg,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [nbits-1:0] out_msg,
   output logic             underflow
);

   localparam logic [nbits-1:0] ONE = {{(nbits-1){1'b0}}, 1'b1};

   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             rdy_q, rdy_d;
   logic [nbits-1:0] mem_q [2];
   logic             enq, deq;

   // Handshakes are taken from registered state only, so neither output path sees in_val/out_rdy.
   assign enq     = in_val & rdy_q;
   assign deq     = out_rdy & out_val;
   assign out_val = (count_q != 2'd0);
   assign out_msg = mem_q[rd_ptr_q];
   assign in_rdy  = rdy_q;

   // Next occupancy and pointers; in_rdy is precomputed from the next occupancy.
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q ^ enq;
      rd_ptr_d = rd_ptr_q ^ deq;
      case ({enq, deq})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      rdy_d = (count_d != 2'd2);
   end

   // Control state; reset drops every stored entry and holds in_rdy low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdy_q    <= rdy_d;
      end
   end

   // Message storage is deliberately unreset; the decode happens on the way in.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_q[wr_ptr_q] <= in_msg - ONE;
      end
   end

`ifdef REG_DECR_SKID_UNDERFLOW_EN
   logic underflow_q;

   // Sticky flag: any accepted zero wraps to all-ones; cleared only by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         underflow_q <= 1'b0;
      end else if (enq && (in_msg == '0)) begin
         underflow_q <= 1'b1;
      end
   end

   assign underflow = underflow_q;
`else
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_reg_decr_skid.sv
module tb_reg_decr_skid;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_val = 1'b0;
   logic       in_rdy;
   logic [7:0] in_msg = 8'h00;
   logic       out_val;
   logic       out_rdy = 1'b0;
   logic [7:0] out_msg;
   logic       underflow;

`ifdef REG_DECR_SKID_UNDERFLOW_EN
   localparam bit UF_EN = 1'b1;
`else
   localparam bit UF_EN = 1'b0;
`endif

   reg_decr_skid #(.nbits(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_val    (in_val),
      .in_rdy    (in_rdy),
      .in_msg    (in_msg),
      .out_val   (out_val),
      .out_rdy   (out_rdy),
      .out_msg   (out_msg),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: a queue of decoded values plus the visible ready/flag state.
   logic [7:0] mq[$];
   logic       m_rdy = 1'b0;
   logic       m_uf  = 1'b0;

   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] im;
      logic       ordy;
      logic       e_rdy;
      logic       e_ov;
      logic [7:0] e_om;
      logic       e_uf;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic add(input logic rst, input logic iv, input logic [7:0] im, input logic ordy,
                      input logic e_rdy, input logic e_ov, input logic [7:0] e_om, input logic e_uf);
      vec_t v;
      v.rst = rst; v.iv = iv; v.im = im; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_om = e_om; v.e_uf = e_uf;
      vq.push_back(v);
   endtask

   // Apply inputs for one cycle, advance past the edge, and update the model from the same inputs.
   task automatic drive(input logic rst, input logic iv, input logic [7:0] im, input logic ordy);
      bit acc, dq;
      reset = rst; in_val = iv; in_msg = im; out_rdy = ordy;
      acc = iv && m_rdy;
      dq  = ordy && (mq.size() > 0);
      @(posedge clk);
      #1;
      if (!rst) begin
         mq.delete();
         m_rdy = 1'b0;
         m_uf  = 1'b0;
      end else begin
         if (dq) void'(mq.pop_front());
         if (acc) begin
            mq.push_back(im - 8'd1);
            if (im == 8'd0 && UF_EN) m_uf = 1'b1;
         end
         m_rdy = (mq.size() < 2);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".in_rdy"}, 32'(in_rdy), 32'(m_rdy));
      chk({tag, ".out_val"}, 32'(out_val), 32'(mq.size() > 0));
      if (mq.size() > 0) chk({tag, ".out_msg"}, 32'(out_msg), 32'(mq[0]));
      chk({tag, ".underflow"}, 32'(underflow), 32'(m_uf));
   endtask

   initial begin
      // rst iv  im     ordy  rdy ov  om     uf(when enabled)
      // reset held 3 cycles with in_val high
      add(0, 1, 8'h55, 1,   0, 0, 8'h00, 0);
      add(0, 1, 8'h55, 1,   0, 0, 8'h00, 0);
      add(0, 1, 8'h55, 1,   0, 0, 8'h00, 0);
      add(1, 0, 8'h00, 1,   1, 0, 8'h00, 0);
      add(1, 0, 8'h00, 1,   1, 0, 8'h00, 0);
      // streaming, no bubbles
      add(1, 1, 8'h01, 1,   1, 1, 8'h00, 0);
      add(1, 1, 8'h05, 1,   1, 1, 8'h04, 0);
      add(1, 1, 8'hFF, 1,   1, 1, 8'hFE, 0);
      add(1, 0, 8'h00, 1,   1, 0, 8'h00, 0);
      // backpressure: fill, hold, drain
      add(1, 1, 8'h10, 0,   1, 1, 8'h0F, 0);
      add(1, 1, 8'h20, 0,   0, 1, 8'h0F, 0);
      add(1, 1, 8'h30, 0,   0, 1, 8'h0F, 0);
      add(1, 0, 8'h00, 1,   1, 1, 8'h1F, 0);
      add(1, 0, 8'h00, 1,   1, 0, 8'h00, 0);
      // full with in_val and out_rdy both high: dequeue only
      add(1, 1, 8'h40, 0,   1, 1, 8'h3F, 0);
      add(1, 1, 8'h50, 0,   0, 1, 8'h3F, 0);
      add(1, 1, 8'h60, 1,   1, 1, 8'h4F, 0);
      add(1, 0, 8'h00, 1,   1, 0, 8'h00, 0);
      // occupancy 1 with simultaneous enqueue/dequeue
      add(1, 1, 8'h70, 0,   1, 1, 8'h6F, 0);
      add(1, 1, 8'h80, 1,   1, 1, 8'h7F, 0);
      add(1, 0, 8'h00, 1,   1, 0, 8'h00, 0);
      // wrap of zero, sticky flag
      add(1, 1, 8'h00, 0,   1, 1, 8'hFF, 1);
      add(1, 0, 8'h00, 1,   1, 0, 8'h00, 1);
      add(1, 1, 8'h02, 1,   1, 1, 8'h01, 1);
      add(1, 0, 8'h00, 1,   1, 0, 8'h00, 1);

      #2;
      foreach (vq[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vq[i].rst, vq[i].iv, vq[i].im, vq[i].ordy);
         chk({tag, ".in_rdy"}, 32'(in_rdy), 32'(vq[i].e_rdy));
         chk({tag, ".out_val"}, 32'(out_val), 32'(vq[i].e_ov));
         if (vq[i].e_ov) chk({tag, ".out_msg"}, 32'(out_msg), 32'(vq[i].e_om));
         chk({tag, ".underflow"}, 32'(underflow), 32'(vq[i].e_uf && UF_EN));
      end

      // Reset in the middle of a full FIFO, with a handshake offered on that same edge.
      drive(1, 1, 8'h11, 0);
      drive(1, 1, 8'h22, 0);
      chk("midrst.full_rdy", 32'(in_rdy), 32'd0);
      chk("midrst.full_msg", 32'(out_msg), 32'h10);
      drive(0, 1, 8'h33, 1);
      chk("midrst.out_val", 32'(out_val), 32'd0);
      chk("midrst.in_rdy", 32'(in_rdy), 32'd0);
      chk("midrst.underflow", 32'(underflow), 32'd0);
      drive(1, 0, 8'h00, 1);
      chk("midrst.rel_rdy", 32'(in_rdy), 32'd1);
      chk("midrst.rel_val", 32'(out_val), 32'd0);
      drive(1, 1, 8'h03, 0);
      chk("midrst.new_val", 32'(out_val), 32'd1);
      chk("midrst.new_msg", 32'(out_msg), 32'h02);
      drive(1, 0, 8'h00, 1);
      chk("midrst.drained", 32'(out_val), 32'd0);

      // Randomized traffic against the queue model.
      for (int c = 0; c < 600; c++) begin
         logic       r_rst, r_iv, r_ordy;
         logic [7:0] r_im;
         r_rst  = ($urandom_range(0, 59) != 0);
         r_iv   = ($urandom_range(0, 3) != 0);
         r_ordy = ($urandom_range(0, 2) != 0);
         r_im   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         drive(r_rst, r_iv, r_im, r_ordy);
         chk_model($sformatf("rnd%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
